frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Frame-level controller for the GPU rasterization pipeline. On each frame request it:
- clears the z-buffer;
- walks a triangle list, issuing one rasterizer job per triangle and waiting for each job's completion;
- waits for vertical sync and flips the double-buffer select.

It sits between the user/host trigger and the rasterizer unit, z-buffer and frame director. It replaces ad-hoc top-level sequencing.

## Interface
Parameters:
- TRI_W, default 4: width of triangle index/count (up to 2^TRI_W − 1 triangles per frame).
- ZB_DEPTH, default 76800: number of z-buffer words to clear (320×240).
- ZB_AW, default 17: z-buffer address width.
- START_CYCLES, default 3: cycles raster_start is held high per job.
- Z_FAR, default 6'h3F: z-buffer clear value.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- frame_start  in  1  frame request; sampled only in IDLE.
- tri_count  in  TRI_W  triangles in this frame; latched when frame_start is accepted.
- tri_idx  out  TRI_W  current triangle index; the top level muxes vertex data to the rasterizer from it.
- raster_start  out  1  rasterizer start strobe.
- raster_done  in  1  rasterizer job-complete.
- zc_we  out  1  z-buffer clear write enable.
- zc_addr  out  ZB_AW  z-buffer clear address.
- zc_wdata  out  6  z-buffer clear data; constant Z_FAR.
- vga_vs  in  1  VGA vertical sync, active low.
- buffer_select  out  1  displayed/drawn buffer select for the frame director.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on buffer swap.

## Operation
States:
- IDLE: frame_start=1 → latch tri_count, clear zc_addr and tri_idx to 0, go to ZCLEAR.
- ZCLEAR:
  - zc_we=1, one word per cycle, zc_addr increments.
  - After the write at ZB_DEPTH−1, go to FETCH, or to WAIT_VS if the latched count is 0.
- FETCH: one cycle, so the vertex mux settles on tri_idx. Then go to START.
- START: raster_start=1 for exactly START_CYCLES cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay until raster_done=1.
  - raster_done is ignored in all other states, including START.
- NEXT:
  - tri_idx+1.
  - If tri_idx+1 == latched count, go to WAIT_VS; else go to FETCH.
- WAIT_VS: wait for a falling edge of vga_vs, detected by comparing with a registered copy.
- SWAP: buffer_select toggles, frame_done=1 for this cycle, go to IDLE.

Rules:
- frame_start is ignored outside IDLE; requests are not queued.
- tri_count changes after acceptance have no effect on the current frame.
- tri_idx holds its last value in IDLE.
- zc_we, raster_start and frame_done are all zero outside their owning states.
- zc_addr counter is ZB_AW bits wide and never wraps within a clear: the exit compare is on ZB_DEPTH−1.

## Timing
- Reset values (the cycle after reset is sampled high):
  - state IDLE, buffer_select 0, tri_idx 0, zc_addr 0;
  - zc_we, raster_start, busy, frame_done all 0;
  - registered vga_vs copy 1.
- Reset mid-frame aborts immediately. buffer_select returns to 0; no frame_done is emitted.
- frame_start sampled at edge N → busy=1 and zc_we=1 with zc_addr=0 after edge N.
- Clear occupies ZB_DEPTH cycles. FETCH occupies 1 cycle, START occupies START_CYCLES cycles.
- raster_done sampled at edge M in WAIT_DONE → NEXT during the next cycle.
- Per-triangle overhead excluding rasterizer time: 1 + START_CYCLES + 1 + 1 cycles.
- vga_vs falling edge seen at edge K in WAIT_VS → SWAP cycle follows; buffer_select toggles at the edge ending SWAP.
- If vga_vs is already low on entry to WAIT_VS, the sequencer still waits for the next falling edge.
- raster_done high on the first WAIT_DONE cycle (a stale level) is accepted. The rasterizer must deassert done within START_CYCLES of start.

## Test plan
- Reset values: assert reset 2 cycles → buffer_select=0, busy=0, all strobes 0. Pulse frame_start during reset → stays IDLE.
- Z-buffer clear (ZB_DEPTH=4, tri_count=0): frame_start → zc_we high 4 consecutive cycles with zc_addr 0,1,2,3 and zc_wdata=6'h3F. No raster_start. On the next vga_vs fall, buffer_select 0→1 and one frame_done pulse.
- Triangle sweep (tri_count=3, raster_done after 10 cycles per job): exactly 3 raster_start bursts of 3 cycles each, with tri_idx = 0,1,2. Done asserted early during START is ignored.
- Vsync gating: hold vga_vs low before WAIT_VS → no swap until vga_vs rises and falls again. Two frames → buffer_select 0→1→0.
- Busy rejection: frame_start pulsed during WAIT_DONE and changing tri_count → no restart, original count honoured, single frame_done.
- Mid-frame reset: reset during ZCLEAR at zc_addr=2 → next cycle IDLE, zc_we=0, buffer_select=0. A fresh frame_start restarts clear at address 0.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame controller: clears the z-buffer, issues one rasterizer job per triangle,
// then waits for a vsync falling edge and flips the display buffer select.
module frame_sequencer #(
  parameter int          TRI_W        = 4,
  parameter int          ZB_DEPTH     = 76800,
  parameter int          ZB_AW        = 17,
  parameter int          START_CYCLES = 3,
  parameter logic [5:0]  Z_FAR        = 6'h3F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [TRI_W-1:0] tri_count,
  output logic [TRI_W-1:0] tri_idx,
  output logic             raster_start,
  input  logic             raster_done,
  output logic             zc_we,
  output logic [ZB_AW-1:0] zc_addr,
  output logic [5:0]       zc_wdata,
  input  logic             vga_vs,
  output logic             buffer_select,
  output logic             busy,
  output logic             frame_done
);

  localparam int SC_W = $clog2(START_CYCLES + 1);
  localparam logic [ZB_AW-1:0] ZC_LAST = ZB_AW'(ZB_DEPTH - 1);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ZCLEAR, S_FETCH, S_START, S_WAIT_DONE, S_NEXT, S_WAIT_VS, S_SWAP
  } state_t;

  state_t           state_q, state_d;
  logic [TRI_W-1:0] count_q, count_d;
  logic [TRI_W-1:0] tri_idx_q, tri_idx_d;
  logic [TRI_W-1:0] tri_nxt;
  logic [ZB_AW-1:0] zc_addr_q, zc_addr_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             bsel_q, bsel_d;
  logic             vs_q, vs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tri_idx_q <= '0;
      zc_addr_q <= '0;
      sc_q      <= '0;
      bsel_q    <= 1'b0;
      vs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tri_idx_q <= tri_idx_d;
      zc_addr_q <= zc_addr_d;
      sc_q      <= sc_d;
      bsel_q    <= bsel_d;
      vs_q      <= vs_d;
    end
  end

  assign tri_nxt = tri_idx_q + TRI_W'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    tri_idx_d    = tri_idx_q;
    zc_addr_d    = zc_addr_q;
    sc_d         = sc_q;
    bsel_d       = bsel_q;
    vs_d         = vga_vs;
    zc_we        = 1'b0;
    raster_start = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          count_d   = tri_count;
          zc_addr_d = '0;
          tri_idx_d = '0;
          state_d   = S_ZCLEAR;
        end
      end
      S_ZCLEAR: begin
        zc_we = 1'b1;
        // Address parks on the last word rather than wrapping.
        if (zc_addr_q == ZC_LAST) begin
          state_d = (count_q == '0) ? S_WAIT_VS : S_FETCH;
        end else begin
          zc_addr_d = zc_addr_q + ZB_AW'(1);
        end
      end
      S_FETCH: begin
        sc_d    = '0;
        state_d = S_START;
      end
      S_START: begin
        raster_start = 1'b1;
        if (sc_q == SC_LAST) state_d = S_WAIT_DONE;
        else                 sc_d    = sc_q + SC_W'(1);
      end
      S_WAIT_DONE: begin
        if (raster_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        tri_idx_d = tri_nxt;
        state_d   = (tri_nxt == count_q) ? S_WAIT_VS : S_FETCH;
      end
      S_WAIT_VS: begin
        if (vs_q && !vga_vs) state_d = S_SWAP;
      end
      S_SWAP: begin
        frame_done = 1'b1;
        bsel_d     = ~bsel_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tri_idx       = tri_idx_q;
  assign zc_addr       = zc_addr_q;
  assign zc_wdata      = Z_FAR;
  assign buffer_select = bsel_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected clear addresses and triangle
// indices are queued at frame launch and consumed as the DUT emits them.
module tb_frame_sequencer;
  localparam int TRI_W = 4, ZB_DEPTH = 4, ZB_AW = 17, START_CYCLES = 3, DONE_DLY = 10;

  logic             clk = 1'b0;
  logic             reset, frame_start, raster_done, vga_vs;
  logic [TRI_W-1:0] tri_count, tri_idx;
  logic             raster_start, zc_we, buffer_select, busy, frame_done;
  logic [ZB_AW-1:0] zc_addr;
  logic [5:0]       zc_wdata;

  int   errors = 0, checks = 0;
  logic exp_bsel = 1'b0;
  int   zq[$];
  int   tq[$];

  frame_sequencer #(.TRI_W(TRI_W), .ZB_DEPTH(ZB_DEPTH), .ZB_AW(ZB_AW),
                    .START_CYCLES(START_CYCLES), .Z_FAR(6'h3F)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .tri_count(tri_count),
    .tri_idx(tri_idx), .raster_start(raster_start), .raster_done(raster_done),
    .zc_we(zc_we), .zc_addr(zc_addr), .zc_wdata(zc_wdata), .vga_vs(vga_vs),
    .buffer_select(buffer_select), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Runs one frame. vs_early holds vsync low from launch; poke re-requests a
  // frame with a different count while the first job is outstanding.
  task automatic run_frame(input string tag, input int cnt, input bit vs_early, input bit poke);
    int burst = 0, waitcnt = 0, jobs = 0, vs_cnt = 0, bursts = 0, e;
    bit prev_rs = 0, vs_phase = 0, dropped = 0, done_pend = 0, finished = 0, fd_seen = 0;
    logic [TRI_W-1:0] tv;
    for (int a = 0; a < ZB_DEPTH; a++) zq.push_back(a);
    for (int t = 0; t < cnt; t++) tq.push_back(t);
    @(negedge clk); tri_count = TRI_W'(cnt); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    if (vs_early) vga_vs = 1'b0;
    for (int it = 0; it < 2000 && !finished; it++) begin
      if (fd_seen) begin
        checks++;
        if (buffer_select !== exp_bsel) begin errors++; $display("FAIL %s bsel_after_swap: got %b want %b", tag, buffer_select, exp_bsel); end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL %s idle_after_swap: busy=%b frame_done=%b want 0 0", tag, busy, frame_done); end
        finished = 1;
      end else begin
        if (done_pend) begin raster_done = 1'b0; done_pend = 0; end
        checks++;
        if (zq.size() != 0) begin
          if (zc_we !== 1'b1) begin
            errors++; $display("FAIL %s zc_gap: zc_we=%b want 1 (%0d words left)", tag, zc_we, zq.size());
            zq.delete();
          end else begin
            e = zq.pop_front();
            if (zc_addr !== ZB_AW'(e)) begin errors++; $display("FAIL %s zc_addr: got %0d want %0d", tag, zc_addr, e); end
            checks++;
            if (zc_wdata !== 6'h3F) begin errors++; $display("FAIL %s zc_wdata: got %h want 3f", tag, zc_wdata); end
          end
        end else if (zc_we !== 1'b0) begin
          errors++; $display("FAIL %s zc_extra: zc_we=%b addr=%0d want zc_we 0", tag, zc_we, zc_addr);
        end
        if (raster_start === 1'b1 && !prev_rs) begin
          bursts++; burst = 1; checks++;
          if (tq.size() == 0) begin
            errors++; $display("FAIL %s extra_burst: burst %0d tri_idx=%0d want none", tag, bursts, tri_idx);
          end else begin
            tv = TRI_W'(tq.pop_front());
            if (tri_idx !== tv) begin errors++; $display("FAIL %s tri_idx: got %0d want %0d", tag, tri_idx, tv); end
          end
          raster_done = 1'b1;  // early done inside START must be ignored
        end else if (raster_start === 1'b1) begin
          burst++; raster_done = 1'b0;
        end else if (prev_rs) begin
          checks++;
          if (burst != START_CYCLES) begin errors++; $display("FAIL %s burst_len: got %0d want %0d", tag, burst, START_CYCLES); end
          waitcnt = DONE_DLY;
        end
        prev_rs = (raster_start === 1'b1);
        if (waitcnt > 0) begin
          waitcnt--;
          if (poke && jobs == 0 && waitcnt == 5) begin frame_start = 1'b1; tri_count = TRI_W'(cnt + 4); end
          if (poke && jobs == 0 && waitcnt == 4) frame_start = 1'b0;
          if (waitcnt == 0) begin raster_done = 1'b1; done_pend = 1; jobs++; end
        end
        if (frame_done === 1'b1) begin
          checks++;
          if (!dropped) begin errors++; $display("FAIL %s early_swap: frame_done=1 before vsync fall, want 0", tag); end
          checks++;
          if (buffer_select !== exp_bsel) begin errors++; $display("FAIL %s bsel_in_swap: got %b want %b", tag, buffer_select, exp_bsel); end
          exp_bsel = ~exp_bsel; fd_seen = 1;
        end
        if (!vs_phase && jobs == cnt && zq.size() == 0 && waitcnt == 0) vs_phase = 1;
        if (vs_phase) begin
          vs_cnt++;
          if (!vs_early && vs_cnt == 5) begin vga_vs = 1'b0; dropped = 1; end
          if (vs_early && vs_cnt == 5) vga_vs = 1'b1;
          if (vs_early && vs_cnt == 8) begin vga_vs = 1'b0; dropped = 1; end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!finished) begin errors++; $display("FAIL %s timeout: frame_done not seen, want 1 pulse", tag); end
    checks++;
    if (tq.size() != 0 || bursts != cnt) begin errors++; $display("FAIL %s bursts: got %0d want %0d", tag, bursts, cnt); end
    vga_vs = 1'b1; raster_done = 1'b0; frame_start = 1'b0;
    zq.delete(); tq.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b1; raster_done = 1'b0; vga_vs = 1'b1; tri_count = 4'd2;
    repeat (2) @(negedge clk);
    frame_start = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || buffer_select !== 1'b0) begin errors++; $display("FAIL reset_state: busy=%b bsel=%b want 0 0", busy, buffer_select); end
    checks++;
    if (zc_we !== 1'b0 || raster_start !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: zc_we=%b rs=%b fd=%b want 0 0 0", zc_we, raster_start, frame_done);
    end
    checks++;
    if (tri_idx !== 4'd0 || zc_addr !== '0) begin errors++; $display("FAIL reset_regs: tri_idx=%0d zc_addr=%0d want 0 0", tri_idx, zc_addr); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
  endtask

  task automatic test_zclear();
    run_frame("zclear", 0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    run_frame("sweep", 3, 1'b0, 1'b0);
    checks++;
    if (tri_idx !== 4'd3) begin errors++; $display("FAIL sweep_idx_hold: got %0d want 3", tri_idx); end
  endtask

  task automatic test_vsync_gating();
    run_frame("vsgate1", 1, 1'b1, 1'b0);
    run_frame("vsgate2", 2, 1'b1, 1'b0);
  endtask

  task automatic test_busy_reject();
    run_frame("busyrej", 2, 1'b0, 1'b1);
  endtask

  task automatic test_midframe_reset();
    bit hit = 0;
    checks++;
    if (buffer_select !== 1'b1) begin errors++; $display("FAIL mid_bsel_pre: got %b want 1", buffer_select); end
    @(negedge clk); tri_count = 4'd2; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (zc_we === 1'b1 && zc_addr === 17'd2) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_addr2: zc_addr=%0d want 2", zc_addr); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || zc_we !== 1'b0 || buffer_select !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%b zc_we=%b bsel=%b fd=%b want 0 0 0 0", busy, zc_we, buffer_select, frame_done);
    end
    reset = 1'b0; exp_bsel = 1'b0;
    run_frame("restart", 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zclear();
    test_sweep();
    test_vsync_gating();
    test_busy_reject();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
